pio_pattern_scheduler: RTL and testbench

PIO_PATTERN_SCHEDULER -- requirements
Module: pio_pattern_scheduler

---
 rtl/pio_pattern_scheduler.sv | 145 ++++++++++++++
 tb/tb_pio_pattern_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pio_pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pio_pattern_scheduler
// Brief   : Round-robin scheduler writing timed motor patterns to an output PIO
//           over Avalon-MM, restoring an idle pattern when work runs out.
// Revision: 1.0 - initial release
// ============================================================================
module pio_pattern_scheduler #(
    parameter int unsigned PRESCALE     = 50000,
    parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_pattern,
    input  logic [15:0] req0_duration,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_pattern,
    input  logic [15:0] req1_duration,
    output logic        req1_ready,
    input  logic        abort,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy,
    output logic        owner
);

    localparam logic [15:0] C_PRESCALE_MAX = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_presc;
    logic [15:0] r_remaining;
    logic [15:0] r_pattern;
    logic [15:0] r_duration;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_busy;
    logic        r_cs;
    logic        r_wn;
    logic [31:0] r_wd;

    logic        w_final;
    logic        w_grant;
    logic        w_winner;
    logic [15:0] w_pattern;
    logic [15:0] w_duration;

    // A grant is possible in IDLE or in the last HOLD cycle unless abort wins.
    always_comb begin
        w_final    = (r_state == S_HOLD) && (r_presc == C_PRESCALE_MAX)
                     && (r_remaining == 16'd1);
        w_winner   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_grant    = ((r_state == S_IDLE) || (w_final && !abort))
                     && (req0_valid || req1_valid);
        w_pattern  = w_winner ? req1_pattern  : req0_pattern;
        w_duration = w_winner ? req1_duration : req0_duration;
    end

    assign req0_ready     = w_grant && !w_winner;
    assign req1_ready     = w_grant &&  w_winner;
    assign pio_address    = 2'b00;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_wn;
    assign pio_writedata  = r_wd;
    assign busy           = r_busy;
    assign owner          = r_owner;

    // Bus outputs are registered on entry to WRITE/CLEAR so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_presc      <= 16'd0;
            r_remaining  <= 16'd0;
            r_pattern    <= 16'd0;
            r_duration   <= 16'd0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_cs         <= 1'b0;
            r_wn         <= 1'b1;
            r_wd         <= 32'd0;
        end else begin
            r_cs <= 1'b0;
            r_wn <= 1'b1;
            r_wd <= 32'd0;
            if (w_grant) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_pattern    <= w_pattern;
                r_duration   <= w_duration;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_WRITE;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b1;
                        r_wn    <= 1'b0;
                        r_wd    <= {16'h0000, w_pattern};
                    end
                end
                S_WRITE: begin
                    r_state     <= S_HOLD;
                    r_presc     <= 16'd0;
                    r_remaining <= (r_duration == 16'd0) ? 16'd1 : r_duration;
                end
                S_HOLD: begin
                    if (abort || (w_final && !w_grant)) begin
                        r_state <= S_CLEAR;
                        r_cs    <= 1'b1;
                        r_wn    <= 1'b0;
                        r_wd    <= {16'h0000, IDLE_PATTERN};
                    end else if (w_final) begin
                        r_state <= S_WRITE;
                        r_cs    <= 1'b1;
                        r_wn    <= 1'b0;
                        r_wd    <= {16'h0000, w_pattern};
                    end else if (r_presc == C_PRESCALE_MAX) begin
                        r_presc     <= 16'd0;
                        r_remaining <= r_remaining - 16'd1;
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_pio_pattern_scheduler
// Brief   : Self-checking bench; expected bus writes are queued at grant time.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pio_pattern_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, abort = 1'b0;
    logic [15:0] req0_pattern = 16'd0, req0_duration = 16'd0;
    logic [15:0] req1_pattern = 16'd0, req1_duration = 16'd0;
    logic        req0_ready, req1_ready, pio_chipselect, pio_write_n, busy, owner;
    logic [1:0]  pio_address;
    logic [31:0] pio_writedata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [15:0] pattern;
        logic [15:0] duration;
        logic        requester;
        int          hold_cycles;
    } vec_t;
    vec_t vecs[4];

    pio_pattern_scheduler #(.PRESCALE(4), .IDLE_PATTERN(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_pattern(req0_pattern),
        .req0_duration(req0_duration), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_pattern(req1_pattern),
        .req1_duration(req1_duration), .req1_ready(req1_ready),
        .abort(abort), .pio_address(pio_address),
        .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every observed write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && pio_chipselect && !pio_write_n) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %h at cycle %0d expected none",
                         pio_writedata, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.data !== pio_writedata || e.cyc != cyc || pio_address !== 2'b00) begin
                    errors++;
                    $display("FAIL pio_write got %h@%0d addr %0d expected %h@%0d addr 0",
                             pio_writedata, cyc, pio_address, e.data, e.cyc);
                end
            end
        end
    end

    task automatic push(input int c, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_busy_fall(input string name, input int exp_cyc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        int t;
        vecs[0] = '{16'hA5A5, 16'd3, 1'b0, 12};
        vecs[1] = '{16'h1234, 16'd1, 1'b1, 4};
        vecs[2] = '{16'hFFFF, 16'd0, 1'b0, 4};
        vecs[3] = '{16'h8001, 16'd2, 1'b1, 8};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_wr_n",   32'(pio_write_n), 32'd1);
        check("rst_cs",     32'(pio_chipselect), 32'd0);
        check("rst_ready",  32'({req0_ready, req1_ready}), 32'd0);
        check("rst_wdata",  pio_writedata, 32'd0);
        check("rst_owner",  32'(owner), 32'd0);

        // Single-requester patterns, including duration 0 behaving as 1.
        foreach (vecs[i]) begin
            wait_idle();
            if (vecs[i].requester) begin
                req1_valid = 1'b1; req1_pattern = vecs[i].pattern; req1_duration = vecs[i].duration;
            end else begin
                req0_valid = 1'b1; req0_pattern = vecs[i].pattern; req0_duration = vecs[i].duration;
            end
            #1;
            t = cyc;
            check("vec_ready", 32'({req1_ready, req0_ready}),
                  vecs[i].requester ? 32'd2 : 32'd1);
            push(t + 1, {16'h0000, vecs[i].pattern});
            push(t + vecs[i].hold_cycles + 2, 32'd0);
            @(posedge clk);
            #1 req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            check("vec_owner", 32'(owner), 32'(vecs[i].requester));
            check("vec_ready_in_write", 32'({req1_ready, req0_ready}), 32'd0);
            wait_busy_fall("vec_busy_fall", t + vecs[i].hold_cycles + 3);
        end

        // Abort in the third HOLD cycle of a duration-5 pattern.
        wait_idle();
        req0_valid = 1'b1; req0_pattern = 16'h00F0; req0_duration = 16'd5;
        #1 t = cyc;
        push(t + 1, 32'h0000_00F0);
        push(t + 5, 32'd0);
        @(posedge clk); #1 req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_busy_fall("abort_busy_fall", t + 6);

        // Reset mid-HOLD: no clear write, master idles immediately.
        wait_idle();
        req0_valid = 1'b1; req0_pattern = 16'h0F0F; req0_duration = 16'd5;
        #1 t = cyc;
        push(t + 1, 32'h0000_0F0F);
        @(posedge clk); #1 req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_cs",   32'(pio_chipselect), 32'd0);
        check("mid_rst_wr_n", 32'(pio_write_n), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        req1_valid = 1'b1; req1_pattern = 16'h0033; req1_duration = 16'd1;
        #1 t = cyc;
        check("post_rst_req1_only", 32'({req1_ready, req0_ready}), 32'd2);
        push(t + 1, 32'h0000_0033);
        push(t + 6, 32'd0);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_busy_fall("post_rst_busy_fall", t + 7);

        // Both valid back to back: req0 first (req1 was last), no clear between.
        wait_idle();
        req0_valid = 1'b1; req0_pattern = 16'h0001; req0_duration = 16'd1;
        req1_valid = 1'b1; req1_pattern = 16'h0002; req1_duration = 16'd1;
        #1 t = cyc;
        check("rr_first_grant", 32'({req1_ready, req0_ready}), 32'd1);
        push(t + 1, 32'h0000_0001);
        push(t + 6, 32'h0000_0002);
        push(t + 11, 32'd0);
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req1_ready) break;
        end
        check("rr_req1_ready_cycle", 32'(cyc), 32'(t + 5));
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        check("rr_owner", 32'(owner), 32'd1);
        wait_busy_fall("rr_busy_fall", t + 12);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
